// File: rtl/interp_sched_pkg.sv
// Shared types and default widths for the interpolating-chain sample scheduler.
//   sched_state_e : scheduler FSM states (IDLE, PRIME, RUN)
//   IN_W, DIV_W, CNT_W : default sample, divider and underflow-counter widths
package interp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } sched_state_e;

  localparam int unsigned IN_W  = 20;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/interp_sample_scheduler_if.sv
// Sample/filter-side bundle of the scheduler.
//   s_data, s_valid, s_ready : upstream sample handshake (s_ready driven by scheduler)
//   filter_ce                : output-rate strobe to the chain clk_enable
//   filter_req               : chain ce_out, requests the next input sample
//   filter_data              : sample presented to the chain input_data
// Modports: slave = scheduler side, master = upstream source / filter chain side.
interface interp_sample_scheduler_if #(
  parameter int unsigned IN_W = interp_sched_pkg::IN_W
);

  logic [IN_W-1:0] s_data;
  logic            s_valid;
  logic            s_ready;
  logic            filter_ce;
  logic            filter_req;
  logic [IN_W-1:0] filter_data;

  modport slave (
    input  s_data, s_valid, filter_req,
    output s_ready, filter_ce, filter_data
  );

  modport master (
    output s_data, s_valid, filter_req,
    input  s_ready, filter_ce, filter_data
  );

endinterface

// File: rtl/interp_sample_fifo.sv
// Synchronous sample FIFO with asynchronous active-high reset.
//   clk, reset      : clock, async active-high reset (all storage cleared)
//   push, wdata     : write request and data; ignored when full
//   pop             : read request; ignored when empty
//   head            : oldest entry (valid when !empty)
//   full, empty     : status flags
//   count           : occupancy, 0..FIFO_DEPTH
// FIFO_DEPTH must be a power of two, minimum 2.
module interp_sample_fifo #(
  parameter int unsigned IN_W       = 20,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [IN_W-1:0]               wdata,
  output logic [IN_W-1:0]               head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [IN_W-1:0] mem_q [FIFO_DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinct.
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic            push_ok;
  logic            pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + PtrOne;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

endmodule

// File: rtl/interp_sample_scheduler.sv
// Rate controller and sample feeder for the inverse-sinc + CIC interpolation chain.
//   clk, reset       : clock, async active-high reset
//   enable           : 1 = stream, 0 = stop
//   div_ratio        : output-rate period is div_ratio+1 clk cycles
//   bus (slave)      : s_data/s_valid/s_ready upstream, filter_ce/filter_req/filter_data chain
//   running          : high in RUN
//   underflow        : one-cycle pulse when a request finds the FIFO empty
//   underflow_count  : saturating underflow count, cleared on each IDLE->PRIME
// Build option: define UNDERFLOW_HOLD_EN to hold the last sample on underflow instead
// of driving zero.
module interp_sample_scheduler #(
  parameter int unsigned IN_W        = interp_sched_pkg::IN_W,
  parameter int unsigned DIV_W       = interp_sched_pkg::DIV_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PRIME_LEVEL = 2,
  parameter int unsigned CNT_W       = interp_sched_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              div_ratio,
  interp_sample_scheduler_if.slave      bus,
  output logic                          running,
  output logic                          underflow,
  output logic [CNT_W-1:0]              underflow_count
);

  import interp_sched_pkg::*;

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PrimeLvl = PRIME_LEVEL[AW:0];

  sched_state_e     state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic             ce_q, ce_d;
  logic [IN_W-1:0]  data_q, data_d;
  logic             uf_q, uf_d;
  logic [CNT_W-1:0] ucnt_q, ucnt_d;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic [IN_W-1:0]  head;

  interp_sample_fifo #(
    .IN_W       (IN_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.s_data),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.s_ready     = !full;
  assign push            = bus.s_valid && !full;
  assign bus.filter_ce   = ce_q;
  assign bus.filter_data = data_q;
  assign running         = (state_q == RUN);
  assign underflow       = uf_q;
  assign underflow_count = ucnt_q;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = '0;
    ratio_d   = ratio_q;
    ce_d      = 1'b0;
    data_d    = data_q;
    uf_d      = 1'b0;
    ucnt_d    = ucnt_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = PRIME;
          ucnt_d  = '0;
        end
      end

      PRIME: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (count >= PrimeLvl) begin
          state_d = RUN;
          ratio_d = div_ratio;
        end
      end

      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (div_cnt_q == ratio_q) begin
          // Wrap: strobe the chain and pick up any new ratio for the next period.
          ce_d    = 1'b1;
          ratio_d = div_ratio;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (bus.filter_req) begin
          if (!empty) begin
            pop    = 1'b1;
            data_d = head;
          end else begin
            // No bypass: a sample pushed on this same edge stays queued.
            uf_d = 1'b1;
            if (ucnt_q != '1) begin
              ucnt_d = ucnt_q + CNT_W'(1);
            end
`ifdef UNDERFLOW_HOLD_EN
            data_d = data_q;
`else
            data_d = '0;
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      ratio_q   <= '0;
      ce_q      <= 1'b0;
      data_q    <= '0;
      uf_q      <= 1'b0;
      ucnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      ratio_q   <= ratio_d;
      ce_q      <= ce_d;
      data_q    <= data_d;
      uf_q      <= uf_d;
      ucnt_q    <= ucnt_d;
    end
  end

endmodule

// File: tb/tb_interp_sample_scheduler.sv
// Directed bench for interp_sample_scheduler. Requests push their expected response into
// a scoreboard queue; a negedge monitor pops and compares on the cycle after each request.
module tb_interp_sample_scheduler;

  typedef struct {
    logic [19:0] data;
    logic        uf;
    logic [15:0] ucnt;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  div_ratio;
  logic        running;
  logic        underflow;
  logic [15:0] underflow_count;

  int    n_vec = 0;
  int    n_err = 0;
  resp_t sb[$];

  interp_sample_scheduler_if #(.IN_W(20)) bus ();

  interp_sample_scheduler #(
    .IN_W        (20),
    .DIV_W       (8),
    .FIFO_DEPTH  (4),
    .PRIME_LEVEL (2),
    .CNT_W       (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .div_ratio       (div_ratio),
    .bus             (bus),
    .running         (running),
    .underflow       (underflow),
    .underflow_count (underflow_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected filter_data after an underflow, given the last served sample.
  function automatic logic [19:0] uf_data(input logic [19:0] last);
`ifdef UNDERFLOW_HOLD_EN
    return last;
`else
    return (last & 20'h0);
`endif
  endfunction

  function automatic resp_t mk(input logic [19:0] d, input logic uf, input logic [15:0] c);
    resp_t e;
    e.data = d;
    e.uf   = uf;
    e.ucnt = c;
    return e;
  endfunction

  task automatic push(input logic [19:0] d);
    @(posedge clk); #1;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic req(input logic [19:0] d, input logic uf, input logic [15:0] c);
    @(posedge clk); #1;
    sb.push_back(mk(d, uf, c));
    bus.filter_req = 1'b1;
    @(posedge clk); #1;
    bus.filter_req = 1'b0;
  endtask

  // Monitor: a request seen at one negedge is served at the next posedge and its
  // response is compared at the negedge after that.
  initial begin
    bit    req_prev;
    resp_t e;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (req_prev) begin
        if (sb.size() == 0) begin
          n_vec = n_vec + 1;
          n_err = n_err + 1;
          $display("FAIL resp_unexpected: got a response, required no pending entry");
        end else begin
          e = sb.pop_front();
          check("resp_data", 32'(bus.filter_data), 32'(e.data));
          check("resp_underflow", 32'(underflow), 32'(e.uf));
          check("resp_ucount", 32'(underflow_count), 32'(e.ucnt));
        end
      end
      req_prev = bus.filter_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    reset          = 1'b1;
    enable         = 1'b0;
    div_ratio      = 8'd0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.filter_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_filter_ce", 32'(bus.filter_ce), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_filter_data", 32'(bus.filter_data), 32'd0);
    check("rst_ucount", 32'(underflow_count), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);

    // Prime with two samples, then stream at ratio 3
    div_ratio = 8'd3;
    push(20'h00011);
    push(20'h00022);
    enable = 1'b1;
    @(negedge clk); check("run_lat0", 32'(running), 32'd0);
    @(negedge clk); check("run_lat1", 32'(running), 32'd0);
    @(negedge clk); check("run_lat2", 32'(running), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("ce_ratio3", 32'(bus.filter_ce), 32'((k % 4) == 0));
    end
    req(20'h00011, 1'b0, 16'd0);
    req(20'h00022, 1'b0, 16'd0);

    // Underflow on an empty FIFO
    req(uf_data(20'h00022), 1'b1, 16'd1);
    req(uf_data(20'h00022), 1'b1, 16'd2);
    req(uf_data(20'h00022), 1'b1, 16'd3);
    @(negedge clk);
    check("uf_count3", 32'(underflow_count), 32'd3);
    @(negedge clk);
    check("uf_pulse_end", 32'(underflow), 32'd0);

    // Push and request on the same edge with an empty FIFO: underflow, sample kept
    @(posedge clk); #1;
    sb.push_back(mk(uf_data(20'h00022), 1'b1, 16'd4));
    bus.s_valid    = 1'b1;
    bus.s_data     = 20'h00033;
    bus.filter_req = 1'b1;
    @(posedge clk); #1;
    bus.s_valid    = 1'b0;
    bus.filter_req = 1'b0;
    req(20'h00033, 1'b0, 16'd4);

    // Fill the FIFO; the fifth sample must be refused
    @(posedge clk); #1;
    bus.s_valid = 1'b1;
    bus.s_data  = 20'h000A1;
    for (int i = 2; i <= 4; i++) begin
      @(posedge clk); #1;
      bus.s_data = 20'h000A0 + 20'(i);
    end
    @(posedge clk); #1;
    bus.s_data = 20'h000A5;
    @(negedge clk);
    check("full_s_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    check("full_s_ready_held", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b0;
    req(20'h000A1, 1'b0, 16'd4);
    @(negedge clk);
    check("after_pop_s_ready", 32'(bus.s_ready), 32'd1);
    req(20'h000A2, 1'b0, 16'd4);
    req(20'h000A3, 1'b0, 16'd4);
    req(20'h000A4, 1'b0, 16'd4);
    req(uf_data(20'h000A4), 1'b1, 16'd5);

    // Ratio change mid-period: 3 -> 1, then 1 -> 0
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = bus.filter_ce;
    end
    check("ce_sync_found", 32'(got), 32'd1);
    div_ratio = 8'd1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("ce_ratio_change", 32'(bus.filter_ce),
            32'((k == 4) || (k > 4 && k <= 12 && (k % 2) == 0) || (k > 12)));
      if (k == 10) div_ratio = 8'd0;
    end

    // Reset mid-RUN with two samples queued
    push(20'h000B1);
    push(20'h000B2);
    push(20'h000B3);
    req(20'h000B1, 1'b0, 16'd5);
    @(negedge clk); #1;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("mid_rst_filter_data", 32'(bus.filter_data), 32'd0);
    check("mid_rst_filter_ce", 32'(bus.filter_ce), 32'd0);
    check("mid_rst_running", 32'(running), 32'd0);
    check("mid_rst_ucount", 32'(underflow_count), 32'd0);
    check("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(running), 32'd0);
    enable = 1'b1;
    push(20'h000C1);
    repeat (3) @(negedge clk);
    check("post_rst_one_sample", 32'(running), 32'd0);
    push(20'h000C2);
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      got = running;
    end
    check("post_rst_run", 32'(got), 32'd1);
    req(20'h000C1, 1'b0, 16'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
